nios_fetch_queue: RTL

- Instruction-fetch front end for the NIOS-II five-stage pipeline. Sits between the instruction memory and the decode stage.
- Issues sequential fetch addresses to a synchronous instruction memory with 1-cycle read latency, and buffers returned words in a DEPTH-entry prefetch FIFO.
- Presents one instruction/PC pair per cycle to decode over a valid/ready handshake.
- A branch redirect from execute flushes the queue and restarts fetch at the target.

---
 rtl/nios_fetch_queue_if.sv | 29 ++
 rtl/nios_fetch_queue.sv | 98 +++++++++
 2 files changed

// File: rtl/nios_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, redirect input and decode handshake.
// The master side is the fetch queue; the slave side is the surrounding pipeline/memory.
interface nios_fetch_queue_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              dec_valid;
    logic [31:0]       dec_inst;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_inst, dec_pc, occupancy,
        input  imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc, occupancy,
        output imem_rdata, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/nios_fetch_queue.sv
// Instruction-fetch front end: sequential prefetch from a 1-cycle imem into a small FIFO,
// presented to decode over valid/ready; a redirect flushes everything and restarts fetch.
module nios_fetch_queue #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nios_fetch_queue_if.master    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q,      tag_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [31:0]       inst_mem_q [DEPTH];
    logic [31:0]       inst_mem_d [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];

    logic imem_req_c;
    logic push_c;
    logic pop_c;

    // Credit check counts the outstanding read so the FIFO can never overflow.
    assign imem_req_c = rst_n & ~bus.redirect_valid &
                        ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    assign push_c     = inflight_q & ~bus.redirect_valid;
    assign pop_c      = (count_q != '0) & bus.dec_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = imem_req_c;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;

        if (imem_req_c) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            tag_d      = fetch_pc_q;
        end
        if (push_c) begin
            inst_mem_d[wr_ptr_q] = bus.imem_rdata;
            pc_mem_d[wr_ptr_q]   = tag_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Redirect overrides everything: the head handshake still counts, the rest is dropped.
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
            inflight_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.dec_valid = (count_q != '0);
    assign bus.dec_inst  = inst_mem_q[rd_ptr_q];
    assign bus.dec_pc    = pc_mem_q[rd_ptr_q];
    assign bus.occupancy = count_q;
endmodule
